// File: rtl/wh_output_arbiter.sv
// rtl/wh_output_arbiter.sv - round-robin wormhole arbiter for one router output port
module wh_output_arbiter #(
    parameter int NPORT = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPORT-1:0] head_req,
    input  logic [NPORT-1:0] in_valid,
    input  logic [NPORT-1:0] in_tail,
    input  logic             out_ready,
    output logic [NPORT-1:0] grant,
    output logic [2:0]       sel,
    output logic             locked,
    output logic             fire,
    output logic [CNT_W-1:0] pkt_count
);

    // Select value that drives no demux output while the port is unowned.
    localparam logic [2:0] SEL_IDLE = 3'b111;
    localparam logic [2:0] LAST_IDX = 3'(NPORT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       sel_q, sel_d;
    logic [NPORT-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             arb_found;
    logic [2:0]       arb_idx;
    logic [3:0]       cand;
    logic             owner_valid;
    logic             owner_tail;
    logic [2:0]       ptr_after_owner;

    // Owner's flit qualifiers; masking with the one-hot grant means the
    // idle select code never indexes the request vectors, and non-owner
    // valid/tail bits cannot leak into the transfer decision.
    always_comb begin
        owner_valid = |(grant_q & in_valid);
        owner_tail  = |(grant_q & in_tail);
    end

    // A flit moves only while locked, the owner presents one and downstream has room.
    always_comb begin
        fire = (state_q == ST_LOCKED) && owner_valid && out_ready;
    end

    // Round-robin search starting at ptr_q, wrapping modulo NPORT; first hit wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = 3'd0;
        cand      = 4'd0;
        for (int i = 0; i < NPORT; i++) begin
            cand = {1'b0, ptr_q} + 4'(i);
            if (cand >= 4'(NPORT)) begin
                cand = cand - 4'(NPORT);
            end
            if (!arb_found && head_req[cand[2:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[2:0];
            end
        end
    end

    // Pointer value that gives priority to the port just after the releasing owner.
    always_comb begin
        if (sel_q >= LAST_IDX) begin
            ptr_after_owner = 3'd0;
        end else begin
            ptr_after_owner = sel_q + 3'd1;
        end
    end

    // Next-state logic: grant on a winning head, hold through body flits,
    // release and advance the pointer when the tail transfers.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d = ST_LOCKED;
                    sel_d   = arb_idx;
                    grant_d = {{(NPORT-1){1'b0}}, 1'b1} << arb_idx;
                end
            end
            ST_LOCKED: begin
                // head_req is deliberately ignored here: the packet owns the
                // channel until its tail goes, however long that takes.
                if (fire && owner_tail) begin
                    state_d = ST_IDLE;
                    sel_d   = SEL_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after_owner;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= SEL_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs straight from state.
    always_comb begin
        grant     = grant_q;
        sel       = sel_q;
        locked    = (state_q == ST_LOCKED);
        pkt_count = cnt_q;
    end

endmodule

// File: tb/tb_wh_output_arbiter.sv
// tb/tb_wh_output_arbiter.sv - vector-table bench for wh_output_arbiter
module tb_wh_output_arbiter;

    logic       clk;
    logic       rst_n;
    logic [4:0] head_req;
    logic [4:0] in_valid;
    logic [4:0] in_tail;
    logic       out_ready;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       locked;
    logic       fire;
    logic [3:0] pkt_count;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [4:0] hr;
        logic [4:0] v;
        logic [4:0] t;
        logic       rdy;
        logic [4:0] eg;
        logic [2:0] es;
        logic       el;
        logic       ef;
        logic [3:0] ec;
    } vec_t;

    vec_t tbl[$];

    wh_output_arbiter #(.NPORT(5), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .head_req  (head_req),
        .in_valid  (in_valid),
        .in_tail   (in_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .locked    (locked),
        .fire      (fire),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] hr, input logic [4:0] v, input logic [4:0] t,
                       input logic rdy, input logic [4:0] eg, input logic [2:0] es,
                       input logic el, input logic ef, input logic [3:0] ec);
        vec_t r;
        r.hr = hr; r.v = v; r.t = t; r.rdy = rdy;
        r.eg = eg; r.es = es; r.el = el; r.ef = ef; r.ec = ec;
        tbl.push_back(r);
    endtask

    // Drive one cycle's inputs, compare outputs at the falling edge, advance past the rising edge.
    task automatic apply(input vec_t r, input string tag);
        head_req  = r.hr;
        in_valid  = r.v;
        in_tail   = r.t;
        out_ready = r.rdy;
        @(negedge clk);
        chk({tag, " grant"},  32'(grant),     32'(r.eg));
        chk({tag, " sel"},    32'(sel),       32'(r.es));
        chk({tag, " locked"}, 32'(locked),    32'(r.el));
        chk({tag, " fire"},   32'(fire),      32'(r.ef));
        chk({tag, " count"},  32'(pkt_count), 32'(r.ec));
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [4:0] hr, input logic [4:0] v, input logic [4:0] t,
                        input logic rdy, input logic [4:0] eg, input logic [2:0] es,
                        input logic el, input logic ef, input logic [3:0] ec, input string tag);
        vec_t r;
        r.hr = hr; r.v = v; r.t = t; r.rdy = rdy;
        r.eg = eg; r.es = es; r.el = el; r.ef = ef; r.ec = ec;
        apply(r, tag);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        head_req  = '0;
        in_valid  = '0;
        in_tail   = '0;
        out_ready = 1'b0;

        // Round robin from ptr 0: N,S,E,W,L,N with an idle cycle before each grant.
        for (int k = 0; k < 6; k++) begin
            add(5'b11111, 5'b11111, 5'b11111, 1'b1, 5'b00000, 3'd7, 1'b0, 1'b0, 4'(k));
            add(5'b11111, 5'b11111, 5'b11111, 1'b1, 5'(1 << (k % 5)), 3'(k % 5), 1'b1, 1'b1, 4'(k));
        end
        // Lone E requester, 3-flit packet (ptr is 1 here).
        add(5'b00100, 5'b00100, 5'b00000, 1'b1, 5'b00000, 3'd7, 1'b0, 1'b0, 4'd6);
        add(5'b00100, 5'b00100, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1, 4'd6);
        add(5'b00100, 5'b00100, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1, 4'd6);
        add(5'b00100, 5'b00100, 5'b00100, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1, 4'd6);
        // All request: pointer left at 3 after E, so W wins.
        add(5'b11111, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd7, 1'b0, 1'b0, 4'd7);
        add(5'b00000, 5'b01000, 5'b01000, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b1, 4'd7);
        // Lock hold: E owns a 4-flit packet while N requests and W toggles valid/tail.
        add(5'b00100, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd7, 1'b0, 1'b0, 4'd8);
        add(5'b00001, 5'b01100, 5'b01000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1, 4'd8);
        add(5'b00001, 5'b01000, 5'b01000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0, 4'd8);
        add(5'b00001, 5'b00100, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1, 4'd8);
        add(5'b00001, 5'b01100, 5'b01000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1, 4'd8);
        add(5'b00001, 5'b01100, 5'b00100, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1, 4'd8);
        add(5'b00001, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd7, 1'b0, 1'b0, 4'd9);
        add(5'b00000, 5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1, 4'd9);

        // Reset held, then released; outputs must show reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst grant",  32'(grant),     32'h00);
        chk("rst sel",    32'(sel),       32'h7);
        chk("rst locked", 32'(locked),    32'h0);
        chk("rst fire",   32'(fire),      32'h0);
        chk("rst count",  32'(pkt_count), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: S owns, five stalled cycles, then tail (ptr 1, count 10).
        step(5'b00010, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd7, 1'b0, 1'b0, 4'd10, "bp idle");
        step(5'b00000, 5'b00010, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1, 4'd10, "bp head");
        for (int i = 0; i < 5; i++) begin
            step(5'b00000, 5'b00010, 5'b00010, 1'b0, 5'b00010, 3'd1, 1'b1, 1'b0, 4'd10,
                 $sformatf("bp stall%0d", i));
        end
        step(5'b00000, 5'b00010, 5'b00010, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1, 4'd10, "bp tail");

        // Counter wrap: six more single-flit packets from N takes the total to 17.
        for (int i = 0; i < 6; i++) begin
            step(5'b00001, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd7, 1'b0, 1'b0,
                 4'((11 + i) % 16), $sformatf("wrap idle%0d", i));
            step(5'b00000, 5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1,
                 4'((11 + i) % 16), $sformatf("wrap fire%0d", i));
        end
        step(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd7, 1'b0, 1'b0, 4'd1, "wrap final");

        // Asynchronous reset mid-packet (pointer is 1, so E alone wins).
        step(5'b00100, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd7, 1'b0, 1'b0, 4'd1, "ar idle");
        head_req  = 5'b00000;
        in_valid  = 5'b00100;
        in_tail   = 5'b00000;
        out_ready = 1'b1;
        #2;
        chk("ar pre fire",  32'(fire),  32'h1);
        chk("ar pre grant", 32'(grant), 32'h04);
        rst_n = 1'b0;
        #1;
        chk("ar grant",  32'(grant),     32'h00);
        chk("ar sel",    32'(sel),       32'h7);
        chk("ar locked", 32'(locked),    32'h0);
        chk("ar fire",   32'(fire),      32'h0);
        chk("ar count",  32'(pkt_count), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Pointer back at 0: all requesting must pick N.
        step(5'b11111, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd7, 1'b0, 1'b0, 4'd0, "post idle");
        step(5'b00000, 5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1, 4'd0, "post grant");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
